score_keeper: RTL

- Produces the 6-digit packed-BCD score word that the display colour mapper renders in the score area.
- Consumes line-clear events from the game logic and computes points = base(lines) × (level+1).
- Uses digit-serial BCD addition, one digit per cycle, so no multipliers or binary-to-BCD converters are needed.
- Commits the finished score atomically, so the display never shows a partially-added value.

---
 rtl/score_keeper.sv | 102 ++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// score_keeper: packed-BCD score accumulator adding base(lines)*(level+1) one digit per cycle.
// Optional HIGH_SCORE_EN macro adds a best-score register; without it high_score_digits is tied to zero.
module score_keeper #(
   parameter int NUM_DIGITS = 6,
   parameter int LEVEL_W    = 4
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_new_game,
   input  logic                    i_evt_valid,
   output logic                    o_evt_ready,
   input  logic [2:0]              i_lines_cleared,
   input  logic [LEVEL_W-1:0]      i_level,
   output logic [4*NUM_DIGITS-1:0] o_score_digits_out,
   output logic                    o_score_updated,
   output logic [4*NUM_DIGITS-1:0] o_high_score_digits
);
   localparam int SW = 4 * NUM_DIGITS;
   typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;
   state_t          r_state, w_next;
   logic [SW-1:0]   r_acc, r_addend, r_score, w_base;
   logic [4:0]      r_reps;
   logic [2:0]      r_idx;
   logic            r_carry, r_upd;
   logic            w_accept, w_last, w_ovf, w_sat;
   logic [4:0]      w_sum;
   logic [3:0]      w_dig;
   assign o_evt_ready        = (r_state == IDLE);
   assign o_score_digits_out = r_score;
   assign o_score_updated    = r_upd;
   assign w_accept = i_evt_valid & o_evt_ready & ~i_new_game;
   assign w_base   = (i_lines_cleared == 3'd1) ? SW'(24'h000040) :
                     (i_lines_cleared == 3'd2) ? SW'(24'h000100) :
                     (i_lines_cleared == 3'd3) ? SW'(24'h000300) :
                     (i_lines_cleared == 3'd4) ? SW'(24'h001200) : '0;
   assign w_sum  = {1'b0, r_acc[{r_idx, 2'b00} +: 4]} + {1'b0, r_addend[{r_idx, 2'b00} +: 4]} + {4'b0, r_carry};
   assign w_ovf  = (w_sum > 5'd9);
   assign w_dig  = w_ovf ? 4'(w_sum - 5'd10) : w_sum[3:0];
   assign w_last = (r_idx == 3'(NUM_DIGITS - 1));
   assign w_sat  = w_last & w_ovf;
   // Next state: new_game wins; zero-point events are absorbed in IDLE; a top-digit carry ends the add early.
   always_comb begin
      w_next = r_state;
      w_next = i_new_game           ? IDLE :
               (r_state == IDLE)    ? ((w_accept && w_base != '0) ? ADD : IDLE) :
               (r_state == ADD)     ? ((w_last && (w_ovf || r_reps == 5'd1)) ? COMMIT : ADD) :
                                      IDLE;
   end
   // State register.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= IDLE;
      else            r_state <= w_next;
   end
   // Datapath: latch the event, add one digit per cycle, publish the accumulator only on COMMIT.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_acc    <= '0;
         r_addend <= '0;
         r_score  <= '0;
         r_reps   <= '0;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_upd    <= 1'b0;
      end else if (i_new_game) begin
         r_acc   <= '0;
         r_score <= '0;
         r_reps  <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_upd   <= 1'b0;
      end else begin
         r_upd <= (r_state == COMMIT);
         if (r_state == COMMIT) r_score <= r_acc;
         if (w_accept) begin
            r_addend <= w_base;
            r_reps   <= 5'(i_level) + 5'd1;
            r_idx    <= '0;
            r_carry  <= 1'b0;
         end else if (r_state == ADD) begin
            if (w_sat) begin
               r_acc <= {NUM_DIGITS{4'h9}};
            end else begin
               r_acc[{r_idx, 2'b00} +: 4] <= w_dig;
               r_idx   <= w_last ? 3'd0 : r_idx + 3'd1;
               r_carry <= w_last ? 1'b0 : w_ovf;
               if (w_last) r_reps <= r_reps - 5'd1;
            end
         end
      end
   end
`ifdef HIGH_SCORE_EN
   logic [SW-1:0] r_high;
   assign o_high_score_digits = r_high;
   // Best score survives new_game; only reset clears it. Packed BCD orders like unsigned binary.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)                                              r_high <= '0;
      else if (r_state == COMMIT && !i_new_game && r_acc > r_high) r_high <= r_acc;
   end
`else
   assign o_high_score_digits = '0;
`endif
endmodule
